// File: rtl/lut_logic_pkg.sv
// Shared op encodings, per-bit logic function and parameter limits for the bitwise logic pipeline.
package lut_logic_pkg;
  localparam int MAX_WIDTH  = 64;
  localparam int MAX_STAGES = 4;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_ANDN = 3'd6,
    OP_PASS = 3'd7
  } op_t;

  // Every op is purely bitwise, so the function is defined on one bit lane and
  // callers apply it across the operand width.
  function automatic logic lut_logic_f(input op_t op, input logic a, input logic b);
    logic r;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NAND: r = ~(a & b);
      OP_NOR:  r = ~(a | b);
      OP_XNOR: r = ~(a ^ b);
      OP_ANDN: r = a & ~b;
      default: r = a;
    endcase
    return r;
  endfunction
endpackage

// File: rtl/lut_logic_reg.sv
// One pipeline stage: 0-cycle added latency beyond its own register, loads data only on valid.
// Frozen while ce=0; no backpressure.
module lut_logic_reg
  import lut_logic_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ce,
  input  logic             d_valid,
  input  logic [WIDTH-1:0] d,
  output logic             q_valid,
  output logic [WIDTH-1:0] q
);
  // On a bubble only the valid bit clears; data keeps its last value.
  always_ff @(posedge clock) begin
    if (reset) begin
      q_valid <= 1'b0;
      q       <= '0;
    end else if (ce) begin
      q_valid <= d_valid;
      if (d_valid) q <= d;
    end
  end
endmodule

// File: rtl/lut_logic_pipe.sv
// Pipelined bitwise logic unit, result STAGES ce-active edges after acceptance; no backpressure, ce stalls all state.
// Optional accumulator operand built when LUT_LOGIC_ACC_EN is defined.
module lut_logic_pipe
  import lut_logic_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ce,
  input  logic             in_valid,
  input  logic [2:0]       op,
  input  logic             acc,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] y
);
  if (WIDTH < 1 || WIDTH > MAX_WIDTH || STAGES < 1 || STAGES > MAX_STAGES) begin : g_param_check
    $error("lut_logic_pipe: WIDTH=%0d STAGES=%0d outside legal range", WIDTH, STAGES);
  end

  logic [WIDTH-1:0] b_sel;
  logic [WIDTH-1:0] f_dat;

  always_comb begin
    f_dat = '0;
    for (int i = 0; i < WIDTH; i++) begin
      f_dat[i] = lut_logic_f(op_t'(op), a[i], b_sel[i]);
    end
  end

`ifdef LUT_LOGIC_ACC_EN
  // Result of this cycle uses the old accumulator; the new result is captured at the same edge.
  logic [WIDTH-1:0] acc_q;
  assign b_sel = acc ? acc_q : b;

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q <= '0;
    end else if (ce && in_valid) begin
      acc_q <= f_dat;
    end
  end
`else
  logic unused_acc;
  assign unused_acc = acc;
  assign b_sel      = b;
`endif

  logic [STAGES:0]  stage_valid;
  logic [WIDTH-1:0] stage_dat [STAGES+1];

  assign stage_valid[0] = in_valid;
  assign stage_dat[0]   = f_dat;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    lut_logic_reg #(.WIDTH(WIDTH)) u_reg (
      .clock   (clock),
      .reset   (reset),
      .ce      (ce),
      .d_valid (stage_valid[s]),
      .d       (stage_dat[s]),
      .q_valid (stage_valid[s+1]),
      .q       (stage_dat[s+1])
    );
  end

  assign out_valid = stage_valid[STAGES];
  assign y         = stage_dat[STAGES];
endmodule
